rv32i_processor: RTL and testbench

//  Self-contained single-cycle RV32I integer core: fetch, decode, execute, memory and writeback all complete in one clock.
//  Top level of the CPU subsystem. Only clock and reset are external; program and data live in internal memories.
//  The bench observes state hierarchically, so these internal names are fixed: pc, regs[0:31], imem[], dmem[].

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/rv32i_processor_if.sv | 15 +
 rtl/riscv_alu.sv | 31 +++
 rtl/rv32i_processor.sv | 196 +++++++++++++++++++
 tb/tb_rv32i_processor.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: opcodes, funct3/funct7 codes and the ALU operation set.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU funct3 codes (shared by OP_IMM and OP_REG)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Word load/store and JALR funct3
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_JALR  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

endpackage

// File: rtl/rv32i_processor_if.sv
// Operand/result bundle between the core's decode logic and its ALU.
interface rv32i_processor_if;

  logic [31:0]            a;
  logic [31:0]            b;
  riscv_pkg::alu_op_e     op;
  logic [31:0]            y;
  logic                   eq;
  logic                   lt;
  logic                   ltu;

  modport master (output a, b, op, input y, eq, lt, ltu);
  modport slave  (input a, b, op, output y, eq, lt, ltu);

endinterface

// File: rtl/riscv_alu.sv
// Purely combinational RV32I ALU with compare flags used for branch resolution.
module riscv_alu
  import riscv_pkg::*;
(
  rv32i_processor_if.slave bus
);

  // Result selection; shifts use only the low 5 bits of b.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    bus.y = bus.a + bus.b;
    case (bus.op)
      ALU_ADD:  bus.y = bus.a + bus.b;
      ALU_SUB:  bus.y = bus.a - bus.b;
      ALU_SLL:  bus.y = bus.a << bus.b[4:0];
      ALU_SLT:  bus.y = {31'b0, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: bus.y = {31'b0, bus.a < bus.b};
      ALU_XOR:  bus.y = bus.a ^ bus.b;
      ALU_SRL:  bus.y = bus.a >> bus.b[4:0];
      ALU_SRA:  bus.y = $unsigned($signed(bus.a) >>> bus.b[4:0]);
      ALU_OR:   bus.y = bus.a | bus.b;
      ALU_AND:  bus.y = bus.a & bus.b;
      default:  bus.y = bus.a + bus.b;
    endcase
  end

  assign bus.eq  = (bus.a == bus.b);
  assign bus.lt  = ($signed(bus.a) < $signed(bus.b));
  assign bus.ltu = (bus.a < bus.b);

endmodule

// File: rtl/rv32i_processor.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback in one clock.
// Optional instruction trace is compiled in when RISCV_PROC_TRACE_EN is defined.
module rv32i_processor
  import riscv_pkg::*;
#(
  parameter int          IMEM_WORDS     = 1024,
  parameter int          DMEM_WORDS     = 1024,
  parameter string       IMEM_INIT_FILE = "program.hex",
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic clk,
  input  logic reset_n
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] regs [0:31];
  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  // Fetch and field extraction
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign instr  = imem[pc[IA+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is hardwired to zero on the read side.
  logic [31:0] rs1_val, rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  // ALU operation and second-operand selection from the instruction alone.
  alu_op_e     alu_op;
  logic        alu_b_rs2;
  logic [31:0] alu_imm;

  always_comb begin
    alu_op    = ALU_ADD;
    alu_b_rs2 = 1'b0;
    alu_imm   = imm_i;
    case (opcode)
      OP_STORE:  alu_imm   = imm_s;
      OP_BRANCH: alu_b_rs2 = 1'b1;
      OP_IMM, OP_REG: begin
        alu_b_rs2 = (opcode == OP_REG);
        case (funct3)
          F3_ADD_SUB: alu_op = (opcode == OP_REG && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SRL_SRA: alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    alu_op = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  rv32i_processor_if alu_bus ();

  assign alu_bus.a  = rs1_val;
  assign alu_bus.b  = alu_b_rs2 ? rs2_val : alu_imm;
  assign alu_bus.op = alu_op;

  riscv_alu u_alu (.bus(alu_bus));

  // Commit control: register write, store enable and next pc. Anything not
  // recognised falls through as a NOP (no writes, pc+4).
  logic        reg_we, mem_we, taken;
  logic [31:0] wb_data, next_pc, pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_data = 32'h0;
    next_pc = pc_plus4;
    taken   = 1'b0;
    case (opcode)
      OP_LUI: begin
        reg_we  = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        reg_we  = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          reg_we  = 1'b1;
          wb_data = pc_plus4;
          next_pc = alu_bus.y & 32'hFFFF_FFFE;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  taken = alu_bus.eq;
          F3_BNE:  taken = !alu_bus.eq;
          F3_BLT:  taken = alu_bus.lt;
          F3_BGE:  taken = !alu_bus.lt;
          F3_BLTU: taken = alu_bus.ltu;
          F3_BGEU: taken = !alu_bus.ltu;
          default: taken = 1'b0;
        endcase
        if (taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == F3_LW_SW) begin
          reg_we  = 1'b1;
          wb_data = dmem[alu_bus.y[DA+1:2]];
        end
      end
      OP_STORE: begin
        mem_we = (funct3 == F3_LW_SW);
      end
      OP_IMM: begin
        wb_data = alu_bus.y;
        case (funct3)
          F3_SLL:     reg_we = (funct7 == F7_BASE);
          F3_SRL_SRA: reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default:    reg_we = 1'b1;
        endcase
      end
      OP_REG: begin
        wb_data = alu_bus.y;
        reg_we  = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
      end
      default: ;
    endcase
  end

  // Program counter: reset to RESET_PC, otherwise advance every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) pc <= RESET_PC;
    else          pc <= next_pc;
  end

  // Register file write port; x0 writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  // Data memory write port; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: memories have no reset so they keep contents through reset and map onto RAM.
    if (reset_n && mem_we) dmem[alu_bus.y[DA+1:2]] <= rs2_val;
  end

`ifdef RISCV_PROC_TRACE_EN
  // Commit trace: one line per instruction plus its register or memory effect.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      $display("PC=%h INSTR=%h", pc, instr);
      if (reg_we && rd != 5'd0) $display("x%0d<=%h", rd, wb_data);
      if (mem_we) $display("M[%h]<=%h", alu_bus.y, rs2_val);
    end
  end
`else
  // Trace disabled: no simulation-only logic is built.
`endif

endmodule

// File: tb/tb_rv32i_processor.sv
// Self-checking bench for rv32i_processor: an instruction-level reference model
// runs alongside the core and every committed cycle is compared against it.
module tb_rv32i_processor;
  import riscv_pkg::*;

  localparam int IW = 64;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  rv32i_processor #(
    .IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_INIT_FILE(""), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n)
  );

  // Stand-alone ALU instance driven directly through the interface.
  rv32i_processor_if alu_bus ();
  riscv_alu u_alu (.bus(alu_bus));

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  logic [31:0] prog   [IW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  // Reference model: executes one instruction from the model's own state.
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, wb, npc, addr;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        we, tk;
    ins = m_imem[(m_pc >> 2) % IW];
    opc = ins[6:0];   rd = ins[11:7];   f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a = m_regs[rs1];  b = m_regs[rs2];
    ii = $signed(ins) >>> 20;
    is = (($signed(ins) >>> 25) << 5) | {27'b0, ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = ins & 32'hFFFF_F000;
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4; we = 1'b0; wb = 32'h0; tk = 1'b0;
    case (opc)
      OP_LUI:   begin we = 1; wb = iu; end
      OP_AUIPC: begin we = 1; wb = m_pc + iu; end
      OP_JAL:   begin we = 1; wb = m_pc + 4; npc = m_pc + ij; end
      OP_JALR:  if (f3 == 3'd0) begin we = 1; wb = m_pc + 4; npc = (a + ii) & ~32'd1; end
      OP_BRANCH: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      OP_LOAD: if (f3 == 3'd2) begin
        addr = a + ii; we = 1; wb = m_dmem[(addr >> 2) % DW];
      end
      OP_STORE: if (f3 == 3'd2) begin
        addr = a + is; m_dmem[(addr >> 2) % DW] = b;
      end
      OP_IMM: begin
        we = 1;
        case (f3)
          3'd0: wb = a + ii;
          3'd2: wb = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: wb = (a < ii) ? 32'd1 : 32'd0;
          3'd4: wb = a ^ ii;
          3'd6: wb = a | ii;
          3'd7: wb = a & ii;
          3'd1: begin we = (f7 == 7'h00); wb = a << ii[4:0]; end
          default: begin
            if (f7 == 7'h00)      wb = a >> ii[4:0];
            else if (f7 == 7'h20) wb = $signed(a) >>> ii[4:0];
            else                  we = 0;
          end
        endcase
      end
      OP_REG: begin
        we = 1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: wb = a + b;
            3'd1: wb = a << b[4:0];
            3'd2: wb = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: wb = (a < b) ? 32'd1 : 32'd0;
            3'd4: wb = a ^ b;
            3'd5: wb = a >> b[4:0];
            3'd6: wb = a | b;
            default: wb = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) wb = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5)     wb = $signed(a) >>> b[4:0];
        else we = 0;
      end
      default: ;
    endcase
    if (we && rd != 5'd0) m_regs[rd] = wb;
    m_pc = npc;
  endtask

  // Model advances on each committing edge.
  always @(posedge clk) if (checking && reset_n) model_step();

  // Compare process: architectural state against the model after every commit.
  always @(negedge clk) begin
    if (checking && reset_n) begin
      check("pc", dut.pc, m_pc);
      for (int i = 1; i < 32; i++) check($sformatf("x%0d", i), dut.regs[i], m_regs[i]);
    end
  end

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic begin_program();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset pc", dut.pc, 32'h0);
    for (int i = 0; i < IW; i++) begin
      dut.imem[i] = prog[i];
      m_imem[i]   = prog[i];
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("reset x%0d", i), dut.regs[i], 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_dmem();
    for (int i = 0; i < DW; i++) check($sformatf("dmem[%0d]", i), dut.dmem[i], m_dmem[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IW; i++) prog[i] = 32'h0;
  endtask

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] imm, r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    imm = $urandom;
    f3  = 3'($urandom_range(0, 7));
    f7  = ($urandom_range(0, 2) == 0) ? F7_ALT : F7_BASE;
    case ($urandom_range(0, 11))
      0, 1: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
        r = enc_i(imm, rreg(), f3, rreg(), OP_IMM);
      end
      2, 3: r = enc_r(f7, rreg(), rreg(), f3, rreg());
      4:    r = enc_u(imm, rreg(), OP_LUI);
      5:    r = enc_u(imm, rreg(), OP_AUIPC);
      6:    r = enc_i(imm, rreg(), ($urandom_range(0, 7) == 0) ? f3 : F3_LW_SW, rreg(), OP_LOAD);
      7:    r = enc_s(imm, rreg(), rreg(), ($urandom_range(0, 7) == 0) ? f3 : F3_LW_SW);
      8:    r = enc_b(32'(($urandom_range(0, 15) - 8) * 4), rreg(), rreg(), f3);
      9:    r = enc_j(32'(($urandom_range(0, 15) - 8) * 4), rreg());
      10:   r = enc_i(imm, rreg(), ($urandom_range(0, 7) == 0) ? f3 : F3_JALR, rreg(), OP_JALR);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      default:  return a & b;
    endcase
  endfunction

  initial begin
    alu_bus.a = 32'h0; alu_bus.b = 32'h0; alu_bus.op = ALU_ADD;
    for (int i = 0; i < DW; i++) begin
      m_dmem[i]   = $urandom;
      dut.dmem[i] = m_dmem[i];
    end
    clear_prog();
    for (int i = 0; i < IW; i++) begin
      dut.imem[i] = 32'h0;
      m_imem[i]   = 32'h0;
    end

    // Power-on reset held for 10 ns
    #1 reset_n = 1'b0;
    #10;
    check("por pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("por x%0d", i), dut.regs[i], 32'h0);

    // Standalone ALU, random operands
    for (int n = 0; n < 300; n++) begin
      alu_bus.a  = $urandom;
      alu_bus.b  = ($urandom_range(0, 7) == 0) ? alu_bus.a : $urandom;
      alu_bus.op = alu_op_e'($urandom_range(0, 9));
      #1;
      check("alu y", alu_bus.y, alu_ref(alu_bus.op, alu_bus.a, alu_bus.b));
      check("alu eq", {31'b0, alu_bus.eq}, (alu_bus.a == alu_bus.b) ? 32'd1 : 32'd0);
      check("alu lt", {31'b0, alu_bus.lt}, ($signed(alu_bus.a) < $signed(alu_bus.b)) ? 32'd1 : 32'd0);
      check("alu ltu", {31'b0, alu_bus.ltu}, (alu_bus.a < alu_bus.b) ? 32'd1 : 32'd0);
    end

    checking = 1'b1;

    // ALU, memory, x0 and illegal word
    clear_prog();
    prog[0]  = enc_i(32'd5, 5'd0, F3_ADD_SUB, 5'd1, OP_IMM);
    prog[1]  = enc_i(-32'sd3, 5'd0, F3_ADD_SUB, 5'd2, OP_IMM);
    prog[2]  = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD_SUB, 5'd3);
    prog[3]  = enc_r(F7_ALT, 5'd2, 5'd1, F3_ADD_SUB, 5'd4);
    prog[4]  = enc_i(32'h401, 5'd2, F3_SRL_SRA, 5'd5, OP_IMM);
    prog[5]  = enc_u(32'h1234_5000, 5'd6, OP_LUI);
    prog[6]  = enc_i(32'h678, 5'd6, F3_ADD_SUB, 5'd6, OP_IMM);
    prog[7]  = enc_s(32'd8, 5'd6, 5'd0, F3_LW_SW);
    prog[8]  = enc_i(32'd8, 5'd0, F3_LW_SW, 5'd7, OP_LOAD);
    prog[9]  = enc_i(32'd7, 5'd0, F3_ADD_SUB, 5'd0, OP_IMM);
    prog[10] = 32'hFFFF_FFFF;
    prog[11] = enc_j(32'd0, 5'd0);
    begin_program();
    run_cycles(13);
    check("add x3", dut.regs[3], 32'd2);
    check("sub x4", dut.regs[4], 32'd8);
    check("srai x5", dut.regs[5], 32'hFFFF_FFFE);
    check("lui/addi x6", dut.regs[6], 32'h1234_5678);
    check("lw x7", dut.regs[7], 32'h1234_5678);
    check("sw dmem[2]", dut.dmem[2], 32'h1234_5678);
    check("x0 stays 0", dut.regs[0], 32'h0);
    check("illegal then hold pc", dut.pc, 32'h2C);
    check_dmem();

    // Branches and jumps
    clear_prog();
    prog[0]  = enc_i(-32'sd1, 5'd0, F3_ADD_SUB, 5'd1, OP_IMM);
    prog[1]  = enc_i(32'd1, 5'd0, F3_ADD_SUB, 5'd2, OP_IMM);
    prog[2]  = enc_b(32'd8, 5'd0, 5'd0, F3_BEQ);
    prog[3]  = enc_i(32'd99, 5'd0, F3_ADD_SUB, 5'd3, OP_IMM);
    prog[4]  = enc_b(32'd8, 5'd2, 5'd1, F3_BLT);
    prog[5]  = enc_i(32'd99, 5'd0, F3_ADD_SUB, 5'd4, OP_IMM);
    prog[6]  = enc_b(32'd8, 5'd2, 5'd1, F3_BLTU);
    prog[7]  = enc_i(32'd7, 5'd0, F3_ADD_SUB, 5'd5, OP_IMM);
    prog[8]  = enc_j(32'd8, 5'd1);
    prog[9]  = enc_j(32'd0, 5'd0);
    prog[10] = enc_i(32'd0, 5'd1, F3_JALR, 5'd0, OP_JALR);
    begin_program();
    run_cycles(7);
    check("jal pc", dut.pc, 32'h28);
    check("jal link x1", dut.regs[1], 32'h24);
    check("beq skipped x3", dut.regs[3], 32'h0);
    check("blt skipped x4", dut.regs[4], 32'h0);
    check("bltu fallthru x5", dut.regs[5], 32'd7);
    run_cycles(1);
    check("jalr pc", dut.pc, 32'h24);
    run_cycles(5);
    check("jal self hold", dut.pc, 32'h24);

    // Free-running loop with a mid-run reset
    clear_prog();
    prog[0] = enc_i(32'd0, 5'd0, F3_ADD_SUB, 5'd1, OP_IMM);
    prog[1] = enc_i(32'd100, 5'd0, F3_ADD_SUB, 5'd2, OP_IMM);
    prog[2] = enc_i(32'd1, 5'd1, F3_ADD_SUB, 5'd1, OP_IMM);
    prog[3] = enc_s(32'd4, 5'd1, 5'd0, F3_LW_SW);
    prog[4] = enc_b(32'hFFFF_FFF8, 5'd2, 5'd1, F3_BNE);
    prog[5] = enc_j(32'd0, 5'd0);
    begin_program();
    run_cycles(50);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrun reset pc", dut.pc, 32'h0);
    check("midrun reset x1", dut.regs[1], 32'h0);
    check("midrun dmem kept", dut.dmem[1], m_dmem[1]);
    @(negedge clk);
    reset_n = 1'b1;
    run_cycles(2000);
    check("loop x1", dut.regs[1], 32'd100);
    check("loop pc", dut.pc, 32'h14);
    check("loop dmem[1]", dut.dmem[1], 32'd100);
    check_dmem();

    // Random programs against the model
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < IW; i++) prog[i] = rand_instr();
      begin_program();
      run_cycles(400);
      check_dmem();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
